// File: rtl/axis_testpattern_checker.sv
// AXI4-Stream sink that locks onto a wrapping counter stream and counts beats and mismatches.
// Back-pressure on tready is generated by a free-running down-counter.
module axis_testpattern_checker #(
    parameter int S00_AXIS_TDATA_WIDTH = 32,
    parameter int COUNTER_START        = 0,
    parameter int COUNTER_END          = 255,
    parameter int COUNTER_INCR         = 1,
    parameter int READY_DIV            = 1,
    parameter int LOSS_THRESHOLD       = 4,
    parameter int COUNT_WIDTH          = 32
) (
    input  logic                            m_axis_aclk,
    input  logic                            m_axis_aresetn,
    input  logic                            enable,
    input  logic                            clear,
    input  logic [S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic                            locked,
    output logic                            error,
    output logic [COUNT_WIDTH-1:0]          beat_count,
    output logic [COUNT_WIDTH-1:0]          error_count,
    output logic [S00_AXIS_TDATA_WIDTH-1:0] expected
);

    localparam int W      = S00_AXIS_TDATA_WIDTH;
    localparam int DIV_W  = (READY_DIV > 1) ? $clog2(READY_DIV) : 1;
    localparam int MISS_W = $clog2(LOSS_THRESHOLD + 1);

    localparam logic [W-1:0]      C_START    = W'(COUNTER_START);
    localparam logic [W-1:0]      C_END      = W'(COUNTER_END);
    localparam logic [W-1:0]      C_INCR     = W'(COUNTER_INCR);
    localparam logic [W-1:0]      WRAP_AT    = C_END - C_INCR + W'(1);
    localparam logic [W-1:0]      WRAP_ADJ   = C_END - C_START + W'(1);
    localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(READY_DIV - 1);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(LOSS_THRESHOLD);

    typedef enum logic [0:0] {
        SYNC   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   tready_q, tready_d;
    logic                   error_q, error_d;
    logic [COUNT_WIDTH-1:0] beat_q, beat_d;
    logic [COUNT_WIDTH-1:0] errcnt_q, errcnt_d;
    logic [W-1:0]           expected_q, expected_d;
    logic [MISS_W-1:0]      miss_q, miss_d;
    logic [MISS_W-1:0]      miss_inc;
    logic                   accept;
    logic                   match;

    // Same increment/wrap rule as the upstream generator, modulo 2^W.
    function automatic logic [W-1:0] next_word(input logic [W-1:0] x);
        if (x >= WRAP_AT)
            return x + C_INCR - WRAP_ADJ;
        else
            return x + C_INCR;
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
        return (&c) ? c : c + COUNT_WIDTH'(1);
    endfunction

    assign accept   = s_axis_tvalid && tready_q;
    assign match    = (s_axis_tdata == expected_q) &&
                      (s_axis_tdata >= C_START) && (s_axis_tdata <= C_END);
    assign miss_inc = miss_q + MISS_W'(1);

    always_comb begin
        div_d      = (div_q == '0) ? DIV_RELOAD : div_q - DIV_W'(1);
        tready_d   = enable && (div_q == '0);
        state_d    = state_q;
        error_d    = 1'b0;
        beat_d     = beat_q;
        errcnt_d   = errcnt_q;
        expected_d = expected_q;
        miss_d     = miss_q;

        // clear wins over a beat accepted on the same edge
        if (clear) begin
            state_d    = SYNC;
            beat_d     = '0;
            errcnt_d   = '0;
            expected_d = C_START;
            miss_d     = '0;
        end else if (accept) begin
            beat_d = sat_inc(beat_q);
            case (state_q)
                SYNC: begin
                    expected_d = next_word(s_axis_tdata);
                    state_d    = LOCKED;
                end
                LOCKED: begin
                    if (match) begin
                        expected_d = next_word(expected_q);
                        miss_d     = '0;
                    end else begin
                        error_d    = 1'b1;
                        errcnt_d   = sat_inc(errcnt_q);
                        expected_d = next_word(s_axis_tdata);
                        if (miss_inc == MISS_LIMIT) begin
                            state_d = SYNC;
                            miss_d  = '0;
                        end else begin
                            miss_d  = miss_inc;
                        end
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q    <= SYNC;
            div_q      <= DIV_RELOAD;
            tready_q   <= 1'b0;
            error_q    <= 1'b0;
            beat_q     <= '0;
            errcnt_q   <= '0;
            expected_q <= C_START;
            miss_q     <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tready_q   <= tready_d;
            error_q    <= error_d;
            beat_q     <= beat_d;
            errcnt_q   <= errcnt_d;
            expected_q <= expected_d;
            miss_q     <= miss_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign locked        = (state_q == LOCKED);
    assign error         = error_q;
    assign beat_count    = beat_q;
    assign error_count   = errcnt_q;
    assign expected      = expected_q;

endmodule

// File: tb/tb_axis_testpattern_checker.sv
// Directed bench for axis_testpattern_checker: three instances cover default, custom-wrap
// and READY_DIV=4 configurations.
module tb_axis_testpattern_checker;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic [31:0] tdata;
    logic        va, vb, vc;

    logic        tr_a, lk_a, er_a;
    logic [31:0] bc_a, ec_a, ex_a;
    logic        tr_b, lk_b, er_b;
    logic [31:0] bc_b, ec_b, ex_b;
    logic        tr_c, lk_c, er_c;
    logic [31:0] bc_c, ec_c, ex_c;

    int checks = 0;
    int passed = 0;

    axis_testpattern_checker u_a (
        .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .enable(enable), .clear(clear),
        .s_axis_tdata(tdata), .s_axis_tvalid(va), .s_axis_tready(tr_a),
        .locked(lk_a), .error(er_a), .beat_count(bc_a), .error_count(ec_a), .expected(ex_a)
    );

    axis_testpattern_checker #(.COUNTER_START(4), .COUNTER_END(20), .COUNTER_INCR(5)) u_b (
        .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .enable(enable), .clear(clear),
        .s_axis_tdata(tdata), .s_axis_tvalid(vb), .s_axis_tready(tr_b),
        .locked(lk_b), .error(er_b), .beat_count(bc_b), .error_count(ec_b), .expected(ex_b)
    );

    axis_testpattern_checker #(.READY_DIV(4)) u_c (
        .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .enable(enable), .clear(clear),
        .s_axis_tdata(tdata), .s_axis_tvalid(vc), .s_axis_tready(tr_c),
        .locked(lk_c), .error(er_c), .beat_count(bc_c), .error_count(ec_c), .expected(ex_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a beat at the falling edge; return 1 time unit after the accepting rising edge.
    task automatic send(input int sel, input logic [31:0] d);
        @(negedge clk);
        tdata = d;
        va = (sel == 0);
        vb = (sel == 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        va = 1'b0;
        vb = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        va = 1'b0;
        vb = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; clear = 1'b0; tdata = '0;
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        #23;
        checks++; if (tr_a !== 1'b0) $display("FAIL reset_tready got %0b want 0", tr_a); else passed++;
        checks++; if ({lk_a, er_a} !== 2'b00) $display("FAIL reset_lock_err got %b want 00", {lk_a, er_a}); else passed++;
        checks++; if ({bc_a, ec_a} !== 64'd0) $display("FAIL reset_counts got %0d/%0d want 0/0", bc_a, ec_a); else passed++;
        checks++; if (ex_b !== 32'd4) $display("FAIL reset_expected_b got %0d want 4", ex_b); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (tr_a !== 1'b1) $display("FAIL tready_after_release got %0b want 1", tr_a); else passed++;
    endtask

    task automatic test_stream();
        int errs = 0;
        send(0, 32'd0);
        checks++; if (lk_a !== 1'b1) $display("FAIL lock_first_beat got %0b want 1", lk_a); else passed++;
        for (int i = 1; i < 259; i++) begin
            send(0, 32'(i % 256));
            if (er_a !== 1'b0) errs++;
        end
        idle();
        checks++; if (errs !== 0) $display("FAIL stream_error_pulses got %0d want 0", errs); else passed++;
        checks++; if (bc_a !== 32'd259) $display("FAIL stream_beats got %0d want 259", bc_a); else passed++;
        checks++; if (ec_a !== 32'd0) $display("FAIL stream_errors got %0d want 0", ec_a); else passed++;
        checks++; if (ex_a !== 32'd3) $display("FAIL stream_expected got %0d want 3", ex_a); else passed++;
    endtask

    task automatic test_drop();
        logic [3:0] pulses;
        do_clear();
        #1;
        checks++; if ({lk_a, bc_a, ec_a, ex_a} !== 97'd0) $display("FAIL clear_state got lk=%0b bc=%0d ec=%0d ex=%0d want 0s", lk_a, bc_a, ec_a, ex_a); else passed++;
        send(0, 32'd10); pulses[0] = er_a;
        send(0, 32'd11); pulses[1] = er_a;
        send(0, 32'd13); pulses[2] = er_a;
        send(0, 32'd14); pulses[3] = er_a;
        idle();
        #1;
        checks++; if (er_a !== 1'b0) $display("FAIL drop_pulse_width got %0b want 0", er_a); else passed++;
        checks++; if (pulses !== 4'b0100) $display("FAIL drop_pulses got %b want 0100", pulses); else passed++;
        checks++; if (ec_a !== 32'd1) $display("FAIL drop_errors got %0d want 1", ec_a); else passed++;
        checks++; if (ex_a !== 32'd15) $display("FAIL drop_expected got %0d want 15", ex_a); else passed++;
        checks++; if ({lk_a, bc_a} !== {1'b1, 32'd4}) $display("FAIL drop_lock_beats got %0b/%0d want 1/4", lk_a, bc_a); else passed++;
    endtask

    task automatic test_wrap();
        int errs = 0;
        logic [31:0] seq [6] = '{32'd4, 32'd9, 32'd14, 32'd19, 32'd7, 32'd12};
        for (int i = 0; i < 6; i++) begin
            send(1, seq[i]);
            if (er_b !== 1'b0) errs++;
        end
        idle();
        checks++; if (errs !== 0 || ec_b !== 32'd0) $display("FAIL wrap_errors got %0d/%0d want 0/0", errs, ec_b); else passed++;
        checks++; if (bc_b !== 32'd6) $display("FAIL wrap_beats got %0d want 6", bc_b); else passed++;
        checks++; if ({lk_b, ex_b} !== {1'b1, 32'd17}) $display("FAIL wrap_expected got %0b/%0d want 1/17", lk_b, ex_b); else passed++;
    endtask

    task automatic test_loss();
        logic [2:0] lk_mid;
        do_clear();
        send(0, 32'd0);
        send(0, 32'd50);  lk_mid[0] = lk_a;
        send(0, 32'd90);  lk_mid[1] = lk_a;
        send(0, 32'd130); lk_mid[2] = lk_a;
        checks++; if (lk_mid !== 3'b111) $display("FAIL loss_lock_held got %b want 111", lk_mid); else passed++;
        send(0, 32'd170);
        checks++; if ({lk_a, ec_a} !== {1'b0, 32'd4}) $display("FAIL loss_drop got %0b/%0d want 0/4", lk_a, ec_a); else passed++;
        send(0, 32'd171);
        checks++; if ({lk_a, er_a} !== 2'b10) $display("FAIL loss_relock got %b want 10", {lk_a, er_a}); else passed++;
        send(0, 32'd172);
        idle();
        checks++; if ({ec_a, ex_a} !== {32'd4, 32'd173}) $display("FAIL loss_after got %0d/%0d want 4/173", ec_a, ex_a); else passed++;
    endtask

    task automatic test_ready_div();
        int highs = 0;
        int doubles = 0;
        logic prev;
        logic [31:0] bc0, ec0, bc1;
        tdata = 32'd0;
        @(negedge clk);
        vc = 1'b1;
        @(posedge clk); #1;
        bc0 = bc_c;
        prev = tr_c;
        for (int i = 0; i < 40; i++) begin
            if (tr_c) highs++;
            @(posedge clk); #1;
            if (tr_c && prev) doubles++;
            prev = tr_c;
        end
        checks++; if (highs !== 10 || doubles !== 0) $display("FAIL div_tready got highs=%0d doubles=%0d want 10/0", highs, doubles); else passed++;
        checks++; if (bc_c - bc0 !== 32'd10) $display("FAIL div_throughput got %0d want 10", bc_c - bc0); else passed++;
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        bc1 = bc_c;
        ec0 = ec_c;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (tr_c) highs++;
        end
        checks++; if (highs !== 0) $display("FAIL disable_tready got %0d highs want 0", highs); else passed++;
        checks++; if ({bc_c, ec_c} !== {bc1, ec0}) $display("FAIL disable_hold got %0d/%0d want %0d/%0d", bc_c, ec_c, bc1, ec0); else passed++;
        @(negedge clk);
        enable = 1'b1;
        vc = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clear_beat();
        do_clear();
        send(0, 32'd0);
        send(0, 32'd5);
        send(0, 32'd9);
        send(0, 32'd20);
        checks++; if ({ec_a, bc_a} !== {32'd3, 32'd4}) $display("FAIL pre_clear got %0d/%0d want 3/4", ec_a, bc_a); else passed++;
        @(negedge clk);
        tdata = 32'd21;
        va = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        checks++; if ({lk_a, bc_a, ec_a, ex_a} !== 97'd0) $display("FAIL clear_beat got lk=%0b bc=%0d ec=%0d ex=%0d want 0s", lk_a, bc_a, ec_a, ex_a); else passed++;
        checks++; if (tr_a !== 1'b1) $display("FAIL clear_tready got %0b want 1", tr_a); else passed++;
        @(negedge clk);
        clear = 1'b0;
        va = 1'b0;
    endtask

    task automatic test_async_reset();
        send(0, 32'd0);
        send(0, 32'd1);
        send(0, 32'd7);
        va = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({tr_a, tr_c} !== 2'b00) $display("FAIL async_tready got %b want 00", {tr_a, tr_c}); else passed++;
        checks++; if ({lk_a, er_a, bc_a, ec_a, ex_a} !== 98'd0) $display("FAIL async_outputs got lk=%0b er=%0b bc=%0d ec=%0d ex=%0d want 0s", lk_a, er_a, bc_a, ec_a, ex_a); else passed++;
        va = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_drop();
        test_wrap();
        test_loss();
        test_ready_div();
        test_clear_beat();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/axis_testpattern_checker.md
Name: axis_testpattern_checker

Overview:
AXI4-Stream sink that sits directly downstream of the test-pattern generator and consumes its wrapping counter stream. It locks onto the first accepted word, predicts every following word using the generator's increment/wrap rule, and counts accepted beats and mismatches. Configurable back-pressure on tready exercises the upstream handshake. Intended for loopback and bring-up tests.

Parameters:
S00_AXIS_TDATA_WIDTH, 32, data width; all counters and arithmetic are this width, modulo 2^W.
COUNTER_START, 0, lowest legal pattern value.
COUNTER_END, 255, highest legal pattern value.
COUNTER_INCR, 1, step between consecutive words.
READY_DIV, 1, tready asserted 1 cycle in READY_DIV while enabled; 1 means always ready.
LOSS_THRESHOLD, 4, consecutive mismatches that drop lock.
COUNT_WIDTH, 32, width of beat_count and error_count.

Ports:
m_axis_aclk  in  1  clock.
m_axis_aresetn  in  1  asynchronous active-low reset.
enable  in  1  1 = accept data; 0 = tready held low.
clear  in  1  sync pulse: zero counters, return to SYNC.
s_axis_tdata  in  W  pattern word.
s_axis_tvalid  in  1  upstream valid.
s_axis_tready  out  1  sink ready.
locked  out  1  1 while in LOCKED.
error  out  1  one-cycle pulse on each counted mismatch.
beat_count  out  COUNT_WIDTH  accepted beats since reset/clear, saturating.
error_count  out  COUNT_WIDTH  mismatches since reset/clear, saturating.
expected  out  W  next predicted word.

Behaviour:
- Reset is asynchronous on m_axis_aresetn low, with synchronous release on m_axis_aclk. Reset values: s_axis_tready=0, locked=0, error=0, beat_count=0, error_count=0, expected=COUNTER_START, div counter=READY_DIV-1, state=SYNC, consecutive-miss counter=0.
- Ready generator: a down-counter decrements every cycle and reloads READY_DIV-1 at zero. s_axis_tready is registered and equals enable AND (counter==0). With READY_DIV=1, tready = enable delayed one cycle.
- A beat is accepted when s_axis_tvalid and s_axis_tready are both high on a rising edge. There is no other state change from the stream.
- next(x) is defined as: if x >= COUNTER_END-COUNTER_INCR+1, then x+COUNTER_INCR-(COUNTER_END-COUNTER_START)-1; otherwise x+COUNTER_INCR. This is W-bit arithmetic and is identical to the generator's rule.
- State SYNC:
  - locked=0.
  - On an accepted beat d: expected<=next(d), beat_count++, go to LOCKED.
  - No errors are counted in SYNC.
- State LOCKED:
  - locked=1.
  - On an accepted beat d: beat_count++.
  - Match condition: d==expected AND COUNTER_START<=d<=COUNTER_END.
  - On match: expected<=next(expected), miss counter<=0.
  - On mismatch: error pulses for 1 cycle, error_count++, expected<=next(d) (resync so a dropped word gives exactly one error), miss counter++.
  - When the miss counter reaches LOSS_THRESHOLD: go to SYNC and zero the miss counter. The error_count increment on that beat still happens.
- Counters saturate at all-ones and do not wrap.
- clear has priority over a beat accepted in the same cycle; that beat is neither counted nor checked. On clear: counters and miss counter <=0, state<=SYNC, expected<=COUNTER_START. tready is not affected by clear.
- enable=0: tready drops on the next edge. State, expected and counters are held. A transfer completes only if tready was already high on that edge.
- Latency: error and count updates are visible 1 cycle after the accepting edge (registered outputs).
- Reset asserted mid-stream returns all outputs to reset values immediately, without waiting for a clock edge.

Test Plan:
- Defaults, generator-like source sends 0..255 then 0,1,2 continuously, READY_DIV=1 -> locked=1 after first beat, error_count=0, beat_count=259 after 259 beats.
- Source sends 10,11,13,14 -> exactly one error pulse on beat 13, error_count=1, expected=15 afterwards, locked stays 1.
- START=4, END=20, INCR=5; source sends 4,9,14,19,7,12 -> error_count=0 (wrap 19->7 accepted as correct).
- LOSS_THRESHOLD=4; lock on 0, then send 50,90,130,170 -> error_count=4, locked=0 after 4th; then 171,172 -> locked=1 after 171, no new errors.
- READY_DIV=4, tvalid held high -> tready high exactly 1 cycle in 4; throughput 1 beat per 4 cycles; toggle enable=0 for 10 cycles -> no beats accepted, counters unchanged.
- Assert clear on the same edge as an accepted beat with error_count=3 -> error_count=0, beat_count=0, locked=0, that beat not counted; async reset mid-burst -> tready=0, all outputs at reset values with no clock edge needed.
